// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the two-requester ALU scheduler
//
// Purpose : opcode encodings, FSM state enum, special-case result constants
//           and the captured-operation record used by alu_scheduler.
// Ports   : none (package).

package alu_sched_pkg;

  localparam int SCHED_DATA_W = 8;
  localparam int SCHED_OP_W   = 3;

  // Opcode encodings; anything above OP_REM is illegal.
  localparam logic [SCHED_OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [SCHED_OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [SCHED_OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [SCHED_OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [SCHED_OP_W-1:0] OP_REM = 3'b100;

  // Result returned for divide by zero and for an illegal opcode.
  localparam logic [SCHED_DATA_W-1:0] DIV0_RESULT    = 8'hFF;
  localparam logic [SCHED_DATA_W-1:0] ILLEGAL_RESULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  // One accepted operation, frozen at acceptance so the requester may
  // change its inputs while the operation is in flight.
  typedef struct packed {
    logic                    id;
    logic [SCHED_DATA_W-1:0] a;
    logic [SCHED_DATA_W-1:0] b;
    logic [SCHED_OP_W-1:0]   op;
  } sched_op_t;

  function automatic logic op_is_legal(input logic [SCHED_OP_W-1:0] op);
    return (op <= OP_REM);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, purely combinational
//
// Purpose : grant one of two requesters; on contention the requester that
//           was not granted last wins.
// Ports   : req  [1:0] in  - request vector, bit i = requester i
//           last       in  - index of the requester granted most recently
//           gnt  [1:0] out - one-hot grant (all zero when no request)

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - arbitrates two requesters onto one ALU, one op in flight
//
// Purpose : IDLE grants one requester (round-robin) and captures its
//           operands, EXEC computes and registers the result, RESP holds
//           the response until the consumer takes it.
// Ports   : clk, rst (async, active high)
//           req0_valid/req0_ready/req0_a/req0_b/req0_op - requester 0
//           req1_valid/req1_ready/req1_a/req1_b/req1_op - requester 1
//           rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_err - response

module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err
);

  sched_state_t      state, state_nxt;
  logic              last_q;
  logic [1:0]        gnt;
  logic              accept;
  sched_op_t         cap_q;
  sched_op_t         cap_nxt;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Acceptance only exists in IDLE; rst also forces it low so no ready
  // pulse leaks out during the asynchronous reset window.
  assign accept = (state == ST_IDLE) && (gnt != 2'b00) && !rst;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req0_ready = accept && gnt[0];
        req1_ready = accept && gnt[1];
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand mux feeding the capture register, selected by the grant.
  always_comb begin
    cap_nxt = cap_q;
    if (gnt[1]) begin
      cap_nxt.id = 1'b1;
      cap_nxt.a  = req1_a;
      cap_nxt.b  = req1_b;
      cap_nxt.op = req1_op;
    end else begin
      cap_nxt.id = 1'b0;
      cap_nxt.a  = req0_a;
      cap_nxt.b  = req0_b;
      cap_nxt.op = req0_op;
    end
  end

  // Capture register and round-robin pointer. The pointer resets to 1 so
  // that requester 0 wins the first contended grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q  <= '0;
      last_q <= 1'b1;
    end else if (accept) begin
      cap_q  <= cap_nxt;
      last_q <= gnt[1];
    end
  end

  // ---------------- ALU on captured operands ----------------
  always_comb begin
    alu_result = ILLEGAL_RESULT;
    alu_err    = 1'b1;
    if (op_is_legal(cap_q.op)) begin
      alu_err = 1'b0;
      case (cap_q.op)
        OP_ADD: alu_result = cap_q.a + cap_q.b;
        OP_SUB: alu_result = cap_q.a - cap_q.b;
        OP_MUL: alu_result = cap_q.a * cap_q.b;
        OP_DIV: begin
          if (cap_q.b == '0) begin
            alu_result = DIV0_RESULT;
            alu_err    = 1'b1;
          end else begin
            alu_result = cap_q.a / cap_q.b;
          end
        end
        OP_REM: begin
          // Remainder by zero passes the dividend through.
          if (cap_q.b == '0) begin
            alu_result = cap_q.a;
            alu_err    = 1'b1;
          end else begin
            alu_result = cap_q.a % cap_q.b;
          end
        end
        default: begin
          alu_result = ILLEGAL_RESULT;
          alu_err    = 1'b1;
        end
      endcase
    end
  end

  // Response registers load only in EXEC, so they stay frozen through RESP
  // however long the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_result <= alu_result;
      rsp_err    <= alu_err;
      rsp_id     <= cap_q.id;
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - self-checking bench for alu_scheduler

module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic       rsp_valid, rsp_id, rsp_err;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (transaction level)
  bit         m_busy = 0;
  int         m_acc  = 0;
  bit         m_last = 1;
  logic       m_id;
  logic [7:0] m_res;
  logic       m_err;
  int         cyc = 0;

  // Responses observed at handshake, for directed checks
  logic       q_id[$];
  logic [7:0] q_res[$];
  logic       q_err[$];

  alu_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arithmetic rules written directly as integer maths.
  function automatic logic [8:0] ref_alu(input int a, input int b, input int op);
    int r;
    bit e;
    e = 0;
    case (op)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = (a * b) % 256;
      3: if (b == 0) begin r = 255; e = 1; end else r = a / b;
      4: if (b == 0) begin r = a;   e = 1; end else r = a % b;
      default: begin r = 0; e = 1; end
    endcase
    return {e, r[7:0]};
  endfunction

  task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                      input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                      input logic rr);
    logic e0, e1, erv;
    @(posedge clk); #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = rr;
    @(negedge clk);
    e0  = !m_busy && v0 && (!v1 || m_last);
    e1  = !m_busy && v1 && (!v0 || !m_last);
    erv = m_busy && (cyc >= m_acc + 2);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp_valid", rsp_valid, erv);
    if (erv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_err", rsp_err, m_err);
      if (rr) begin
        q_id.push_back(rsp_id);
        q_res.push_back(rsp_result);
        q_err.push_back(rsp_err);
        m_busy = 0;
      end
    end
    if (e0 || e1) begin
      m_busy = 1;
      m_acc  = cyc;
      m_last = e1;
      m_id   = e1;
      {m_err, m_res} = e1 ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h5A, 8'hA5, 3'd7, 0, 8'hC3, 8'h3C, 3'd7, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_id", rsp_id, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_busy = 0;
    m_last = 1;
  endtask

  task automatic clear_q();
    q_id.delete();
    q_res.delete();
    q_err.delete();
  endtask

  initial begin
    do_reset();

    // add 200+100 from requester 0
    clear_q();
    step(1, 8'd200, 8'd100, 3'd0, 0, 8'd0, 8'd0, 3'd0, 1);
    idle(3);
    chk("add_count", q_res.size(), 1);
    chk("add_result", q_res[0], 8'd44);
    chk("add_err", q_err[0], 0);
    chk("add_id", q_id[0], 0);

    // both continuously valid: alternation starting with requester 0
    do_reset();
    clear_q();
    for (int i = 0; i < 9; i++) step(1, 8'd16, 8'd17, 3'd2, 1, 8'd5, 8'd7, 3'd1, 1);
    idle(1);
    chk("rr_count", q_res.size(), 3);
    chk("rr_id0", q_id[0], 0);
    chk("rr_res0", q_res[0], 8'h10);
    chk("rr_id1", q_id[1], 1);
    chk("rr_res1", q_res[1], 8'hFE);
    chk("rr_id2", q_id[2], 0);
    chk("rr_res2", q_res[2], 8'h10);

    // divide and remainder by zero from requester 1
    do_reset();
    clear_q();
    step(0, 8'd0, 8'd0, 3'd0, 1, 8'd9, 8'd0, 3'd3, 1);
    idle(2);
    step(0, 8'd0, 8'd0, 3'd0, 1, 8'd9, 8'd0, 3'd4, 1);
    idle(3);
    chk("dz_count", q_res.size(), 2);
    chk("div0_res", q_res[0], 8'hFF);
    chk("div0_err", q_err[0], 1);
    chk("rem0_res", q_res[1], 8'h09);
    chk("rem0_err", q_err[1], 1);
    chk("rem0_id", q_id[1], 1);

    // illegal opcode with 5-cycle consumer stall while both keep requesting
    do_reset();
    clear_q();
    step(1, 8'd3, 8'd4, 3'd6, 0, 8'd0, 8'd0, 3'd0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'd3, 8'd4, 3'd6, 1, 8'd1, 8'd1, 3'd0, 0);
    step(0, 8'd0, 8'd0, 3'd0, 0, 8'd0, 8'd0, 3'd0, 1);
    idle(2);
    chk("ill_count", q_res.size(), 1);
    chk("ill_res", q_res[0], 8'h00);
    chk("ill_err", q_err[0], 1);

    // reset while a divide is in EXEC discards it
    do_reset();
    clear_q();
    step(1, 8'd100, 8'd7, 3'd3, 0, 8'd0, 8'd0, 3'd0, 1);
    do_reset();
    idle(4);
    chk("discard_count", q_res.size(), 0);
    step(1, 8'd1, 8'd1, 3'd0, 0, 8'd0, 8'd0, 3'd0, 1);
    idle(3);
    chk("post_rst_count", q_res.size(), 1);
    chk("post_rst_res", q_res[0], 8'd2);
    chk("post_rst_id", q_id[0], 0);

    // randomized traffic, operands re-randomized every cycle
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 6,
           8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 6,
           8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 7);
      if (i == 700) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 Parameter OP_W, default 3, opcode width; only 3 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 presents an operation.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready.
REQ-007 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-008 req0_op  input  3  requester 0 opcode.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths/meaning as requester 0.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result when valid&ready.
REQ-012 rsp_id  output  1  requester index owning the result.
REQ-013 rsp_result  output  8  operation result.
REQ-014 rsp_err  output  1  illegal opcode or divide/remainder by zero.

Function
REQ-015 Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 rem; 101-111 illegal.
REQ-016 add/sub modulo 256; mul returns low 8 bits of product; div/rem unsigned.
REQ-017 div with b=0 -> result 8'hFF, err=1; rem with b=0 -> result=a, err=1.
REQ-018 Illegal opcode -> result 8'h00, err=1; no X ever driven on any output.
REQ-019 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-020 IDLE: if any valid, grant one requester, assert only its ready combinationally, capture a/b/op/id on the edge, go EXEC.
REQ-021 IDLE with no valid: both ready low, stay IDLE.
REQ-022 Arbitration round-robin: single valid wins; both valid -> requester not granted last wins.
REQ-023 Priority pointer updates at acceptance to the granted index.
REQ-024 EXEC: compute from captured operands, register result/err/id, go RESP.
REQ-025 RESP: rsp_valid high, outputs stable until rsp_ready; on valid&ready return to IDLE.
REQ-026 Latency: accept at edge T -> rsp_valid high in cycle after edge T+2 (2 cycles); max throughput one op per 3 cycles with rsp_ready tied high.
REQ-027 Both ready low in EXEC and RESP regardless of valid.
REQ-028 Requester may change/drop operands after acceptance without affecting in-flight result.
REQ-029 rsp_ready ignored outside RESP.

Reset
REQ-030 rst asserted: state IDLE, rsp_valid=0, rsp_result=0, rsp_err=0, rsp_id=0, pointer=1 (requester 0 first), immediately without clock.
REQ-031 rst mid-EXEC or mid-RESP discards the in-flight operation; no response issued.
REQ-032 Ready outputs low while rst high.

Structure
REQ-033 Shared package alu_sched_pkg holds opcode constants, FSM state enum, div-by-zero and illegal-op result constants.
REQ-034 One sub-module rr_arb2: two requests, priority pointer in, one-hot grant out, combinational.
REQ-035 Arithmetic in a single combinational case block inside alu_scheduler on captured operands.

Verification
REQ-036 After reset, req0 valid a=8'd200,b=8'd100,op=000 -> req0_ready=1 one cycle, 2 cycles later rsp_result=8'd44, err=0, id=0.
REQ-037 req0 and req1 continuously valid (req0 mul 16*17, req1 sub 5-7), rsp_ready=1 -> responses alternate id 0,1,0: 8'h10, 8'hFE, 8'h10.
REQ-038 req1 div a=9,b=0 then rem a=9,b=0 -> results 8'hFF err=1, 8'h09 err=1.
REQ-039 op=110 a=3,b=4 -> result 8'h00, err=1; rsp_ready low 5 cycles -> rsp_valid and outputs held, both ready low, then single handshake.
REQ-040 rst pulsed in EXEC of div 100/7 -> no response after release; next add 1+1 from req0 returns 8'd2, id=0.
